// File: rtl/map_access_arbiter.sv
// ---------------------------------------------------------------------------
// map_access_arbiter
//
// Gives three requesters access to the single port of the map storage
// (ROWS x COLS cells, CELL_W bits each; cell 0 sits in the top bits of the row
// word). Each access is run through a small FSM. Grants are round-robin, but
// render wins outright when it asks during a frame boundary (v_sync).
//
// Ports:
//   clock, reset                  clock; asynchronous active-high reset
//   i_v_sync                      frame boundary, gives render priority
//   i_ed_*  / o_ed_ack, o_ed_err  editor cell write (req, row, col, wdata)
//   i_rb_*  / o_rb_ack, o_rb_err, robot cell read (req, row, col)
//             o_rb_rdata
//   i_rn_*  / o_rn_ack, o_rn_err, render full-row read (req, row)
//             o_rn_rdata
//   o_mem_row, o_mem_col,         storage address, write enable, write data
//   o_mem_we, o_mem_wdata
//   i_mem_rdata                   storage row word, one cycle after o_mem_row
//   o_busy                        FSM not idle
//   o_last_grant                  0 editor, 1 robot, 2 render, 3 none yet
// ---------------------------------------------------------------------------
module map_access_arbiter #(
    parameter int ROWS   = 10,
    parameter int COLS   = 20,
    parameter int CELL_W = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_v_sync,
    input  logic                   i_ed_req,
    input  logic [3:0]             i_ed_row,
    input  logic [4:0]             i_ed_col,
    input  logic [CELL_W-1:0]      i_ed_wdata,
    output logic                   o_ed_ack,
    output logic                   o_ed_err,
    input  logic                   i_rb_req,
    input  logic [3:0]             i_rb_row,
    input  logic [4:0]             i_rb_col,
    output logic                   o_rb_ack,
    output logic                   o_rb_err,
    output logic [CELL_W-1:0]      o_rb_rdata,
    input  logic                   i_rn_req,
    input  logic [3:0]             i_rn_row,
    output logic                   o_rn_ack,
    output logic                   o_rn_err,
    output logic [COLS*CELL_W-1:0] o_rn_rdata,
    output logic [3:0]             o_mem_row,
    output logic [4:0]             o_mem_col,
    output logic                   o_mem_we,
    output logic [CELL_W-1:0]      o_mem_wdata,
    input  logic [COLS*CELL_W-1:0] i_mem_rdata,
    output logic                   o_busy,
    output logic [1:0]             o_last_grant
);

    localparam int ROW_W = COLS * CELL_W;
    localparam logic [3:0] ROW_LIMIT = 4'(ROWS);
    localparam logic [4:0] COL_LIMIT = 5'(COLS);

    localparam logic [1:0] GR_ED   = 2'd0;
    localparam logic [1:0] GR_RB   = 2'd1;
    localparam logic [1:0] GR_RN   = 2'd2;
    localparam logic [1:0] GR_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_ACK
    } state_t;

    state_t              r_state;
    logic [1:0]          r_rrPtr;
    logic [1:0]          r_who;
    logic [4:0]          r_opCol;
    logic                r_edAck, r_edErr;
    logic                r_rbAck, r_rbErr;
    logic                r_rnAck, r_rnErr;
    logic [CELL_W-1:0]   r_rbRdata;
    logic [ROW_W-1:0]    r_rnRdata;
    logic [3:0]          r_memRow;
    logic [4:0]          r_memCol;
    logic                r_memWe;
    logic [CELL_W-1:0]   r_memWdata;
    logic                r_busy;
    logic [1:0]          r_lastGrant;

    logic [2:0]          w_reqVec;
    logic [2:0]          w_cand;
    logic                w_grantValid;
    logic [1:0]          w_grant;
    logic [1:0]          w_nextPtr;
    logic [3:0]          w_opRow;
    logic [4:0]          w_opCol;
    logic                w_rangeErr;
    logic [CELL_W-1:0]   w_cell;

    // Winner selection. A v_sync render grant leaves the pointer alone so the
    // round-robin turn it pre-empted is still owed to the same requester.
    always_comb begin
        w_reqVec     = {i_rn_req, i_rb_req, i_ed_req};
        w_cand       = 3'd0;
        w_grantValid = 1'b0;
        w_grant      = GR_NONE;
        w_nextPtr    = r_rrPtr;
        if (i_v_sync && i_rn_req) begin
            w_grantValid = 1'b1;
            w_grant      = GR_RN;
        end else begin
            for (int k = 0; k < 3; k++) begin
                w_cand = {1'b0, r_rrPtr} + 3'(k);
                if (w_cand >= 3'd3) begin
                    w_cand = w_cand - 3'd3;
                end
                if (!w_grantValid && w_reqVec[w_cand[1:0]]) begin
                    w_grantValid = 1'b1;
                    w_grant      = w_cand[1:0];
                    w_nextPtr    = (w_cand[1:0] == 2'd2) ? 2'd0 : w_cand[1:0] + 2'd1;
                end
            end
        end
    end

    // Operands of the prospective winner; render has no column, so it can only
    // fail on the row.
    always_comb begin
        w_opRow = i_ed_row;
        w_opCol = i_ed_col;
        case (w_grant)
            GR_RB: begin
                w_opRow = i_rb_row;
                w_opCol = i_rb_col;
            end
            GR_RN: begin
                w_opRow = i_rn_row;
                w_opCol = 5'd0;
            end
            default: ;
        endcase
        w_rangeErr = (w_opRow >= ROW_LIMIT) || (w_opCol >= COL_LIMIT);
    end

    // Cell 0 is the most significant cell of the row word.
    always_comb begin
        w_cell = '0;
        for (int c = 0; c < COLS; c++) begin
            if (r_opCol == 5'(c)) begin
                w_cell = i_mem_rdata[ROW_W-1-CELL_W*c -: CELL_W];
            end
        end
    end

    // Access sequencer. Async reset clears mem_we at once so a transaction cut
    // by reset can never complete a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rrPtr     <= 2'd0;
            r_who       <= GR_NONE;
            r_opCol     <= 5'd0;
            r_edAck     <= 1'b0;
            r_edErr     <= 1'b0;
            r_rbAck     <= 1'b0;
            r_rbErr     <= 1'b0;
            r_rnAck     <= 1'b0;
            r_rnErr     <= 1'b0;
            r_rbRdata   <= '0;
            r_rnRdata   <= '0;
            r_memRow    <= 4'd0;
            r_memCol    <= 5'd0;
            r_memWe     <= 1'b0;
            r_memWdata  <= '0;
            r_busy      <= 1'b0;
            r_lastGrant <= GR_NONE;
        end else begin
            r_edAck <= 1'b0;
            r_edErr <= 1'b0;
            r_rbAck <= 1'b0;
            r_rbErr <= 1'b0;
            r_rnAck <= 1'b0;
            r_rnErr <= 1'b0;
            r_memWe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grantValid) begin
                        r_who       <= w_grant;
                        r_lastGrant <= w_grant;
                        r_rrPtr     <= w_nextPtr;
                        r_opCol     <= w_opCol;
                        r_busy      <= 1'b1;
                        if (w_rangeErr) begin
                            case (w_grant)
                                GR_ED:   begin r_edAck <= 1'b1; r_edErr <= 1'b1; end
                                GR_RB:   begin r_rbAck <= 1'b1; r_rbErr <= 1'b1; end
                                default: begin r_rnAck <= 1'b1; r_rnErr <= 1'b1; end
                            endcase
                            r_state <= ST_ACK;
                        end else begin
                            r_memRow <= w_opRow;
                            if (w_grant == GR_ED) begin
                                r_memCol   <= w_opCol;
                                r_memWdata <= i_ed_wdata;
                                r_memWe    <= 1'b1;
                            end
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_who == GR_ED) begin
                        r_edAck <= 1'b1;
                        r_state <= ST_ACK;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (r_who == GR_RB) begin
                        r_rbRdata <= w_cell;
                        r_rbAck   <= 1'b1;
                    end else begin
                        r_rnRdata <= i_mem_rdata;
                        r_rnAck   <= 1'b1;
                    end
                    r_state <= ST_ACK;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ed_ack     = r_edAck;
    assign o_ed_err     = r_edErr;
    assign o_rb_ack     = r_rbAck;
    assign o_rb_err     = r_rbErr;
    assign o_rb_rdata   = r_rbRdata;
    assign o_rn_ack     = r_rnAck;
    assign o_rn_err     = r_rnErr;
    assign o_rn_rdata   = r_rnRdata;
    assign o_mem_row    = r_memRow;
    assign o_mem_col    = r_memCol;
    assign o_mem_we     = r_memWe;
    assign o_mem_wdata  = r_memWdata;
    assign o_busy       = r_busy;
    assign o_last_grant = r_lastGrant;

endmodule

// File: tb/tb_map_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_map_access_arbiter
//
// Directed bench for map_access_arbiter. A behavioural map storage sits on the
// memory port; expected ack results are queued when a request is raised and
// checked by a monitor when the matching ack appears.
// ---------------------------------------------------------------------------
module tb_map_access_arbiter;

    localparam int ROWS   = 10;
    localparam int COLS   = 20;
    localparam int CELL_W = 3;
    localparam int ROW_W  = COLS * CELL_W;

    localparam int WHO_ED = 0;
    localparam int WHO_RB = 1;
    localparam int WHO_RN = 2;

    localparam logic [ROW_W-1:0] ROW9_INIT = 60'hFFF000000000ABC;
    localparam logic [ROW_W-1:0] ROW1_CELL1_IS_2 = 60'h080000000000000;

    typedef struct {
        int               who;
        logic             err;
        logic [ROW_W-1:0] data;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              vSync;
    logic              edReq, rbReq, rnReq;
    logic [3:0]        edRow, rbRow, rnRow;
    logic [4:0]        edCol, rbCol;
    logic [CELL_W-1:0] edWdata;
    logic              edAck, edErr, rbAck, rbErr, rnAck, rnErr;
    logic [CELL_W-1:0] rbRdata;
    logic [ROW_W-1:0]  rnRdata;
    logic [3:0]        memRow;
    logic [4:0]        memCol;
    logic              memWe;
    logic [CELL_W-1:0] memWdata;
    logic [ROW_W-1:0]  memRdata;
    logic              busy;
    logic [1:0]        lastGrant;

    logic [ROW_W-1:0]  mapMem [ROWS];
    logic              loadMap;

    exp_t              sbQueue [$];
    exp_t              monExp;
    int                monAckSum;
    int                monWho;
    logic              monErr;

    int                total = 0;
    int                bad = 0;
    int                weCount = 0;
    logic [3:0]        weRow;
    logic [4:0]        weCol;
    logic [CELL_W-1:0] weData;
    int                weBefore;
    int                waitCycles;

    map_access_arbiter #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .CELL_W (CELL_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_v_sync     (vSync),
        .i_ed_req     (edReq),
        .i_ed_row     (edRow),
        .i_ed_col     (edCol),
        .i_ed_wdata   (edWdata),
        .o_ed_ack     (edAck),
        .o_ed_err     (edErr),
        .i_rb_req     (rbReq),
        .i_rb_row     (rbRow),
        .i_rb_col     (rbCol),
        .o_rb_ack     (rbAck),
        .o_rb_err     (rbErr),
        .o_rb_rdata   (rbRdata),
        .i_rn_req     (rnReq),
        .i_rn_row     (rnRow),
        .o_rn_ack     (rnAck),
        .o_rn_err     (rnErr),
        .o_rn_rdata   (rnRdata),
        .o_mem_row    (memRow),
        .o_mem_col    (memCol),
        .o_mem_we     (memWe),
        .o_mem_wdata  (memWdata),
        .i_mem_rdata  (memRdata),
        .o_busy       (busy),
        .o_last_grant (lastGrant)
    );

    always #5 clock = ~clock;

    // Behavioural map storage: cell writes on the edge ending a mem_we cycle,
    // registered row read one cycle after the address.
    always @(posedge clock) begin
        if (loadMap) begin
            for (int r = 0; r < ROWS; r++) begin
                mapMem[r] <= '0;
            end
            mapMem[9] <= ROW9_INIT;
        end else if (memWe && (memRow < 4'(ROWS)) && (memCol < 5'(COLS))) begin
            mapMem[memRow][ROW_W-1-CELL_W*int'(memCol) -: CELL_W] <= memWdata;
        end
        if (memRow < 4'(ROWS)) begin
            memRdata <= mapMem[memRow];
        end else begin
            memRdata <= '0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Monitor: records storage writes and checks every ack against the
    // scoreboard head, including which requester, err, rdata and last_grant.
    always @(negedge clock) begin
        if (memWe) begin
            weCount++;
            weRow  = memRow;
            weCol  = memCol;
            weData = memWdata;
        end
        monAckSum = int'(edAck) + int'(rbAck) + int'(rnAck);
        if (monAckSum > 1) begin
            checkOutput("one_ack_only", 64'(monAckSum), 64'd1);
        end else if (monAckSum == 1) begin
            monWho = edAck ? WHO_ED : (rbAck ? WHO_RB : WHO_RN);
            monErr = edAck ? edErr : (rbAck ? rbErr : rnErr);
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_ack", 64'({rnAck, rbAck, edAck}), 64'd0);
            end else begin
                monExp = sbQueue.pop_front();
                checkOutput("ack_who", 64'(monWho), 64'(monExp.who));
                checkOutput("ack_err", 64'(monErr), 64'(monExp.err));
                checkOutput("ack_last_grant", 64'(lastGrant), 64'(monExp.who));
                if (rbAck) begin
                    checkOutput("rb_rdata", 64'(rbRdata), 64'(monExp.data));
                end
                if (rnAck) begin
                    checkOutput("rn_rdata", 64'(rnRdata), 64'(monExp.data));
                end
            end
        end
    end

    // Raises one request from an idle DUT, queues its expected result and
    // measures the cycles until its ack; leaves the DUT idle again.
    task automatic applyStimulus(input int who, input logic [3:0] row,
                                 input logic [4:0] col, input logic [CELL_W-1:0] wdata,
                                 input logic expErr, input logic [ROW_W-1:0] expData,
                                 input int expLat, input string tag);
        exp_t e;
        int   lat;
        logic seen;
        e.who  = who;
        e.err  = expErr;
        e.data = expData;
        sbQueue.push_back(e);
        case (who)
            WHO_ED: begin
                edRow = row; edCol = col; edWdata = wdata; edReq = 1'b1;
            end
            WHO_RB: begin
                rbRow = row; rbCol = col; rbReq = 1'b1;
            end
            default: begin
                rnRow = row; rnReq = 1'b1;
            end
        endcase
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clock);
            lat++;
            seen = (who == WHO_ED) ? edAck : ((who == WHO_RB) ? rbAck : rnAck);
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
        edReq = 1'b0;
        rbReq = 1'b0;
        rnReq = 1'b0;
        @(negedge clock);
    endtask

    task automatic drainQueue(input string tag);
        waitCycles = 0;
        while (sbQueue.size() != 0 && waitCycles < 100) begin
            @(negedge clock);
            #1;
            waitCycles++;
        end
        checkOutput({tag, "_drained"}, 64'(sbQueue.size()), 64'd0);
        edReq = 1'b0;
        rbReq = 1'b0;
        rnReq = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset   = 1'b1;
        loadMap = 1'b1;
        vSync   = 1'b0;
        edReq   = 1'b0; rbReq = 1'b0; rnReq = 1'b0;
        edRow   = '0;   edCol = '0;   edWdata = '0;
        rbRow   = '0;   rbCol = '0;   rnRow = '0;

        repeat (2) @(negedge clock);
        checkOutput("rst_acks", 64'({edAck, rbAck, rnAck}), 64'd0);
        checkOutput("rst_errs", 64'({edErr, rbErr, rnErr}), 64'd0);
        checkOutput("rst_mem_we", 64'(memWe), 64'd0);
        checkOutput("rst_rb_rdata", 64'(rbRdata), 64'd0);
        checkOutput("rst_rn_rdata", 64'(rnRdata), 64'd0);
        checkOutput("rst_mem_addr", 64'({memRow, memCol, memWdata}), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_last_grant", 64'(lastGrant), 64'd3);
        loadMap = 1'b0;
        reset   = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_last_grant", 64'(lastGrant), 64'd3);
        end

        weBefore = weCount;
        applyStimulus(WHO_ED, 4'd2, 5'd5, 3'b101, 1'b0, '0, 2, "ed_write");
        checkOutput("ed_we_cycles", 64'(weCount - weBefore), 64'd1);
        checkOutput("ed_we_row", 64'(weRow), 64'd2);
        checkOutput("ed_we_col", 64'(weCol), 64'd5);
        checkOutput("ed_we_data", 64'(weData), 64'b101);
        applyStimulus(WHO_RB, 4'd2, 5'd5, '0, 1'b0, 60'b101, 3, "rb_read_2_5");
        applyStimulus(WHO_RN, 4'd9, 5'd0, '0, 1'b0, ROW9_INIT, 3, "rn_read_9");
        applyStimulus(WHO_RB, 4'd9, 5'd19, '0, 1'b0, 60'b100, 3, "rb_read_9_19");

        weBefore = weCount;
        applyStimulus(WHO_RB, 4'd10, 5'd0, '0, 1'b1, 60'b100, 1, "rb_row_oor");
        applyStimulus(WHO_ED, 4'd0, 5'd20, 3'b111, 1'b1, '0, 1, "ed_col_oor");
        applyStimulus(WHO_RN, 4'd12, 5'd0, '0, 1'b1, ROW9_INIT, 1, "rn_row_oor");
        checkOutput("oor_no_write", 64'(weCount - weBefore), 64'd0);

        sbQueue.push_back('{WHO_ED, 1'b0, '0});
        sbQueue.push_back('{WHO_RB, 1'b0, 60'b101});
        sbQueue.push_back('{WHO_RN, 1'b0, ROW1_CELL1_IS_2});
        sbQueue.push_back('{WHO_ED, 1'b0, '0});
        edRow = 4'd1; edCol = 5'd1; edWdata = 3'd2;
        rbRow = 4'd2; rbCol = 5'd5;
        rnRow = 4'd1;
        edReq = 1'b1; rbReq = 1'b1; rnReq = 1'b1;
        drainQueue("rr_all_three");

        applyStimulus(WHO_RN, 4'd9, 5'd0, '0, 1'b0, ROW9_INIT, 3, "rn_realign");

        sbQueue.push_back('{WHO_RN, 1'b0, ROW9_INIT});
        sbQueue.push_back('{WHO_ED, 1'b0, '0});
        sbQueue.push_back('{WHO_RB, 1'b0, 60'd2});
        edRow = 4'd3; edCol = 5'd3; edWdata = 3'd7;
        rbRow = 4'd1; rbCol = 5'd1;
        rnRow = 4'd9;
        vSync = 1'b1;
        edReq = 1'b1; rbReq = 1'b1; rnReq = 1'b1;
        @(negedge clock);
        vSync = 1'b0;
        drainQueue("vsync_ptr0");

        sbQueue.push_back('{WHO_RN, 1'b0, ROW9_INIT});
        sbQueue.push_back('{WHO_RN, 1'b0, ROW9_INIT});
        sbQueue.push_back('{WHO_ED, 1'b0, '0});
        vSync = 1'b1;
        edReq = 1'b1; rnReq = 1'b1;
        @(negedge clock);
        vSync = 1'b0;
        drainQueue("vsync_ptr2");

        edRow = 4'd4; edCol = 5'd4; edWdata = 3'd6; edReq = 1'b1;
        @(negedge clock);
        checkOutput("issue_we_high", 64'(memWe), 64'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("reset_we_async", 64'(memWe), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        edReq = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        checkOutput("post_reset_last_grant", 64'(lastGrant), 64'd3);
        applyStimulus(WHO_RB, 4'd4, 5'd4, '0, 1'b0, '0, 3, "cell_4_4_unchanged");

        checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait above never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
Shares the single port of the map storage (10 rows x 20 cells x 3 bits, row word 60 bits, cell 0 in bits [59:57]) between three requesters. The requesters are the cursor editor (cell writes), the robot sensor logic (cell reads for head/left/under/barrier) and the sprite/render scanner (full-row reads). The block sits between those requesters and the map register file inside the map module. It sequences every access through a small FSM with round-robin fairness and a frame-boundary priority for render.

Parameters:
ROWS, 10, number of map rows; valid row index 0..ROWS-1
COLS, 20, cells per row; valid column index 0..COLS-1
CELL_W, 3, bits per cell; row word width = COLS*CELL_W (60)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
v_sync  in  1  frame boundary; gives render priority
ed_req  in  1  editor write request, held until ed_ack
ed_row  in  4  editor target row
ed_col  in  5  editor target column
ed_wdata  in  3  cell value to write
ed_ack  out  1  one-cycle completion pulse
ed_err  out  1  valid with ed_ack; 1 = address out of range, nothing written
rb_req  in  1  robot cell-read request, held until rb_ack
rb_row  in  4  robot query row
rb_col  in  5  robot query column
rb_ack  out  1  one-cycle completion pulse
rb_err  out  1  valid with rb_ack; 1 = out of range
rb_rdata  out  3  cell value; valid with rb_ack, held until next robot ack
rn_req  in  1  render row-read request, held until rn_ack
rn_row  in  4  render row index
rn_ack  out  1  one-cycle completion pulse
rn_err  out  1  valid with rn_ack; 1 = out of range
rn_rdata  out  60  full row word; valid with rn_ack, held until next render ack
mem_row  out  4  storage row address
mem_col  out  5  storage column, for writes
mem_we  out  1  storage write enable; storage writes on the edge ending the cycle
mem_wdata  out  3  storage write data
mem_rdata  in  60  storage row word; registered, valid one cycle after mem_row
busy  out  1  FSM not in IDLE
last_grant  out  2  0 = editor, 1 = robot, 2 = render, 3 = none since reset

Behaviour:
- All outputs registered.
- Reset values: all acks, errs and mem_we = 0; rb_rdata = 0; rn_rdata = 0; mem_row, mem_col, mem_wdata = 0; busy = 0; last_grant = 3; rr_ptr = 0; FSM in IDLE.
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE: requests are sampled on each edge.
  - If v_sync = 1 and rn_req = 1, render wins and rr_ptr is unchanged.
  - Otherwise the first asserted request in circular order starting at rr_ptr wins; rr_ptr then becomes (winner+1) mod 3.
  - The winner's operands are latched and last_grant is updated.
- Range check at the grant edge: row >= ROWS, or col >= COLS for editor/robot, is an error.
  - Go directly to ACK with err = 1.
  - No storage access; mem_we stays 0; rdata outputs unchanged.
- Write path (editor): IDLE -> ISSUE -> ACK -> IDLE.
  - In ISSUE, mem_we = 1 for exactly one cycle with mem_row, mem_col and mem_wdata set.
  - ed_ack is high during the cycle after ISSUE.
- Read path (robot, render): IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE.
  - ISSUE drives mem_row.
  - CAPTURE samples mem_rdata. Robot gets the cell from bits [59-3*col -: 3]; render gets all 60 bits.
  - ACK pulses the matching ack.
  - Latency, counted from the grant edge E0: ack is high between E2 and E3 for reads; between E1 and E2 for writes; between E0 and E1 for errors.
- Handshake:
  - The requester keeps req and operands stable until its ack and drops req on the edge ending the ack cycle.
  - A req still high in the cycle after ack is a new request.
  - Operand changes while granted are ignored, because operands are latched at grant.
- Outside ISSUE: mem_we = 0; mem_row, mem_col and mem_wdata hold their last values.
- Only one ack is asserted in any cycle.
- Requests arriving while busy wait. No requests are dropped.
- Reset asserted mid-transaction: mem_we drops immediately (asynchronously), so no partial write occurs. The FSM returns to IDLE, no ack is issued, and the requester re-requests after reset.

Test Plan:
- Reset then idle: all outputs at reset values, last_grant = 3, busy = 0 for 5 cycles with no requests.
- Editor write row 2, col 5, data 3'b101: mem_we high exactly one cycle with mem_row = 2, mem_col = 5; ed_ack one cycle later with ed_err = 0. A following robot read of (2,5) returns rb_rdata = 3'b101.
- Render read row 9 with the storage row preset to 60'hFFF000000000ABC: rn_ack in the 3rd cycle after grant with rn_rdata = 60'hFFF000000000ABC. Robot read (9,19) returns 3'b100.
- Out of range: robot (10,0) and editor (0,20) each give ack with err = 1 one cycle after grant; mem_we never asserted; rb_rdata unchanged.
- Fairness: all three req held continuously with v_sync = 0 gives grant order editor, robot, render, editor. With v_sync = 1 in an IDLE cycle, render is granted next, rr_ptr is unchanged, and the editor remains next for the round-robin grant.
- Reset asserted during the editor ISSUE cycle: mem_we falls immediately, the storage cell is unchanged, and no ack is seen after reset is released.
